sim_ctrl: RTL

//   Parametrised simulation run controller for sccpu-class cores and their multi-hart successors.
//   - Sequences core reset and bounds the run with a cycle watchdog.
//   - Detects per-hart completion via tohost writes and reports pass/fail, exit code and run statistics.
//   - Replaces hand-timed reset/#delay/$finish sequencing in benches; the bench waits on done.

---
 rtl/sim_ctrl_pkg.sv | 27 ++
 rtl/sim_ctrl_if.sv | 55 +++++
 rtl/sim_ctrl_hart.sv | 44 ++++
 rtl/sim_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// Shared types and helpers for the simulation run controller.
// Imported by the interface, per-hart tracker and top level.
package sim_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
    DRAIN,
    DONE
  } sim_state_t;

  localparam int unsigned TOHOST_PASS = 1;
  localparam int unsigned POP_W = 256;

  function automatic logic [8:0] popcount(
    input logic [POP_W-1:0] v
  );
    logic [8:0] n;
    n = '0;
    for (int i = 0; i < POP_W; i++) begin
      n = n + 9'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sim_ctrl_if.sv
// Bench-facing bundle of the run controller: control, per-hart
// strobes/data and run results.
interface sim_ctrl_if #(
  parameter int unsigned NUM_HARTS = 1,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_W     = 32
);

  logic                      start;
  logic                      core_rst;
  logic [NUM_HARTS-1:0]      retire_valid;
  logic [NUM_HARTS-1:0]      tohost_we;
  logic [NUM_HARTS*XLEN-1:0] tohost_data;
  logic                      running;
  logic                      done;
  logic                      pass;
  logic                      timeout;
  logic [XLEN-1:0]           exit_code;
  logic [NUM_HARTS-1:0]      hart_done;
  logic [CNT_W-1:0]          cycle_count;
  logic [CNT_W-1:0]          instret_total;

  modport master (
    output start,
    output retire_valid,
    output tohost_we,
    output tohost_data,
    input  core_rst,
    input  running,
    input  done,
    input  pass,
    input  timeout,
    input  exit_code,
    input  hart_done,
    input  cycle_count,
    input  instret_total
  );

  modport slave (
    input  start,
    input  retire_valid,
    input  tohost_we,
    input  tohost_data,
    output core_rst,
    output running,
    output done,
    output pass,
    output timeout,
    output exit_code,
    output hart_done,
    output cycle_count,
    output instret_total
  );

endinterface

// File: rtl/sim_ctrl_hart.sv
// Per-hart completion tracker: first tohost write in RUN decides
// pass/fail; later writes are ignored until cleared.
module sim_ctrl_hart
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_en,
  input  logic            clear,
  input  logic            we,
  input  logic [XLEN-1:0] data,
  output logic            done,
  output logic            passed,
  output logic            fail_valid,
  output logic [XLEN-1:0] code
);

  logic            hit;
  logic            pass_hit;
  logic            passed_q;
  logic [XLEN-1:0] code_q;

  assign hit        = run_en & we & ~done;
  assign pass_hit   = hit & (data == XLEN'(TOHOST_PASS));
  assign fail_valid = hit & ~pass_hit;
  // Includes this cycle's write so the top sees it on exit.
  assign passed     = passed_q | pass_hit;
  assign code       = fail_valid ? (data >> 1) : code_q;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      done     <= 1'b0;
      passed_q <= 1'b0;
      code_q   <= '0;
    end else if (hit) begin
      done     <= 1'b1;
      passed_q <= pass_hit;
      if (fail_valid) code_q <= data >> 1;
    end
  end

endmodule

// File: rtl/sim_ctrl.sv
// Simulation run controller: core reset sequencing, watchdog,
// per-hart tohost completion and run statistics.
module sim_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned NUM_HARTS    = 1,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned MAX_CYCLES   = 100000,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input logic       clk,
  input logic       rst,
  sim_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

  sim_state_t           state;
  logic [31:0]          rst_cnt;
  logic [31:0]          drain_cnt;
  logic                 fail_seen;
  logic                 run_en;
  logic                 clear;
  logic                 all_now;
  logic                 wd_hit;
  logic [NUM_HARTS-1:0] hart_done;
  logic [NUM_HARTS-1:0] passed;
  logic [NUM_HARTS-1:0] fail_valid;
  logic [XLEN-1:0]      codes [NUM_HARTS];
  logic [XLEN-1:0]      first_code;
  logic [CNT_W-1:0]     retire_sum;
  logic [CNT_W:0]       inst_add;
  logic [CNT_W-1:0]     inst_next;
  logic [CNT_W-1:0]     cyc_next;

  assign run_en = (state == RUN);
  assign clear  = bus.start & ((state == IDLE) | (state == DONE));

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
    sim_ctrl_hart #(.XLEN(XLEN)) u_hart (
      .clk        (clk),
      .rst        (rst),
      .run_en     (run_en),
      .clear      (clear),
      .we         (bus.tohost_we[g]),
      .data       (bus.tohost_data[g*XLEN +: XLEN]),
      .done       (hart_done[g]),
      .passed     (passed[g]),
      .fail_valid (fail_valid[g]),
      .code       (codes[g])
    );
  end

  assign bus.hart_done = hart_done;

  // Lowest hart index wins a same-cycle failure tie.
  always_comb begin
    first_code = '0;
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      if (fail_valid[i]) first_code = codes[i];
    end
  end

  assign all_now    = &(hart_done | bus.tohost_we);
  assign wd_hit     = (MAX_CYCLES != 0) &&
                      (bus.cycle_count == WD_LAST);
  assign retire_sum = CNT_W'(popcount(POP_W'(bus.retire_valid)));
  assign inst_add   = {1'b0, bus.instret_total} + {1'b0, retire_sum};
  assign inst_next  = inst_add[CNT_W] ? '1 : inst_add[CNT_W-1:0];
  assign cyc_next   = (&bus.cycle_count) ? bus.cycle_count
                                         : bus.cycle_count + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      bus.core_rst      <= 1'b1;
      bus.running       <= 1'b0;
      bus.done          <= 1'b0;
      bus.pass          <= 1'b0;
      bus.timeout       <= 1'b0;
      bus.exit_code     <= '0;
      bus.cycle_count   <= '0;
      bus.instret_total <= '0;
      rst_cnt           <= '0;
      drain_cnt         <= '0;
      fail_seen         <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state             <= RESET;
            bus.core_rst      <= 1'b1;
            bus.running       <= 1'b0;
            bus.done          <= 1'b0;
            bus.pass          <= 1'b0;
            bus.timeout       <= 1'b0;
            bus.exit_code     <= '0;
            bus.cycle_count   <= '0;
            bus.instret_total <= '0;
            fail_seen         <= 1'b0;
            rst_cnt           <= 32'(RESET_CYCLES - 1);
          end
        end
        RESET: begin
          if (rst_cnt == 0) begin
            state        <= RUN;
            bus.core_rst <= 1'b0;
            bus.running  <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - 1;
          end
        end
        RUN: begin
          bus.cycle_count   <= cyc_next;
          bus.instret_total <= inst_next;
          if (!fail_seen && |fail_valid) begin
            fail_seen     <= 1'b1;
            bus.exit_code <= first_code;
          end
          if (all_now) begin
            if (DRAIN_CYCLES == 0) begin
              state        <= DONE;
              bus.core_rst <= 1'b1;
              bus.running  <= 1'b0;
              bus.done     <= 1'b1;
              bus.pass     <= &passed;
            end else begin
              state     <= DRAIN;
              drain_cnt <= 32'(DRAIN_CYCLES - 1);
            end
          end else if (wd_hit) begin
            state        <= DONE;
            bus.core_rst <= 1'b1;
            bus.running  <= 1'b0;
            bus.done     <= 1'b1;
            bus.timeout  <= 1'b1;
            bus.pass     <= 1'b0;
          end
        end
        DRAIN: begin
          bus.instret_total <= inst_next;
          if (drain_cnt == 0) begin
            state        <= DONE;
            bus.core_rst <= 1'b1;
            bus.running  <= 1'b0;
            bus.done     <= 1'b1;
            bus.pass     <= &passed;
          end else begin
            drain_cnt <= drain_cnt - 1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
